// File: rtl/instr_encoder_loader_if.sv
// Handshake and instruction-memory bus for instr_encoder_loader.
//   Field side : in_valid/in_ready handshake carrying in_class, in_alu, in_rd, in_rs1,
//                in_rs2, in_imm and in_last.
//   Memory side: imem_we strobe with imem_addr (ADDR_W bits) and imem_wdata (32 bits).
// master = producer of fields / consumer of memory writes; slave = the loader.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [2:0]        in_alu;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Program loader: takes symbolic instruction fields over a valid/ready handshake, encodes each
// into a 32-bit RV32I word and writes the words to consecutive imem addresses from 0.
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-high reset
//   start           pulse, begins a new load at word address 0
//   bus (slave)     field handshake in, imem write bus out (see instr_encoder_loader_if)
//   busy            accepting or writing
//   done            load finished (last instruction written or imem full)
//   err             sticky, an accepted instruction was illegal and dropped
//   count           words written since start
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       count
);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic        alu_ok;
  logic        fits12, fits13, fits21;
  logic        legal;
  logic [31:0] enc_word;

  assign imm = bus.in_imm;

  // Range checks as "upper bits are pure sign extension".
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    funct3 = 3'b000;
    alu_ok = 1'b1;
    case (bus.in_alu)
      3'b000:  funct3 = 3'b000;  // add
      3'b001:  funct3 = 3'b000;  // sub
      3'b010:  funct3 = 3'b111;  // and
      3'b011:  funct3 = 3'b110;  // or
      3'b101:  funct3 = 3'b010;  // slt
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    enc_word = '0;
    legal    = 1'b0;
    case (bus.in_class)
      3'b000: begin  // R
        enc_word = {(bus.in_alu == 3'b001) ? 7'b0100000 : 7'b0000000, bus.in_rs2, bus.in_rs1,
                    funct3, bus.in_rd, 7'b0110011};
        legal    = alu_ok;
      end
      3'b001: begin  // I-ALU (no subi in RV32I)
        enc_word = {imm[11:0], bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
        legal    = alu_ok && (bus.in_alu != 3'b001) && fits12;
      end
      3'b010: begin  // LW
        enc_word = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
        legal    = fits12;
      end
      3'b011: begin  // SW
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
        legal    = fits12;
      end
      3'b100: begin  // BEQ
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000, imm[4:1], imm[11],
                    7'b1100011};
        legal    = fits13 && !imm[0];
      end
      3'b101: begin  // JAL
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
        legal    = fits21 && !imm[0];
      end
      default: begin
        enc_word = '0;
        legal    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StAccept;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StAccept: begin
        // A restart wins over a simultaneous handshake; those fields are discarded.
        if (start) begin
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (bus.in_valid) begin
          if (legal) begin
            wdata_d = enc_word;
            last_d  = bus.in_last;
            state_d = StWrite;
          end else begin
            err_d = 1'b1;
            if (bus.in_last) state_d = StDone;
          end
        end
      end
      StWrite: begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        // Stop on the last slot instead of wrapping onto word 0.
        state_d = (last_q || (&ptr_q)) ? StDone : StAccept;
      end
    endcase

    in_ready_d = (state_d == StAccept);
    we_d       = (state_d == StWrite);
    busy_d     = (state_d == StAccept) || (state_d == StWrite);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = ptr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign count          = count_q;

endmodule
